// File: rtl/ps_bc_slct_seq.sv
// ps_bc_slct_seq: registered bus-connect DRR/DI select decode with pipeline hold;
// the two-beat long-word sequencer is present only when PS_BC_LW_EN is defined.
module ps_bc_slct_seq #(
  parameter int UREG_W = 4,
  parameter logic [2**UREG_W-1:0] SEL2_MASK = 16'h0001,
  parameter logic [2**UREG_W-1:0] SEL1_MASK = 16'h00C0,
  parameter logic [2**UREG_W-1:0] SEL0_MASK = 16'h0006
) (
  input  logic              clk_dcd,
  input  logic              ps_rst_n,
  input  logic              ps_imminst,
  input  logic              ps_dmimminst,
  input  logic              ps_popstck,
  input  logic              ps_pshstck,
  input  logic              ps_dminst,
  input  logic              ps_dmiaddinst,
  input  logic              ps_urgtrnsinst,
  input  logic              ps_dm_wrb,
  input  logic              ps_lw,
  input  logic              ps_hold,
  input  logic [UREG_W-1:0] ps_ureg1_add,
  input  logic [UREG_W-1:0] ps_ureg2_add,
  output logic [1:0]        ps_bc_drr_slct,
  output logic [1:0]        ps_bc_di_slct,
  output logic              ps_bc_beat,
  output logic              ps_bc_busy
);
  typedef enum logic [2:0] {C_IMM, C_POP, C_RD, C_WR, C_UR, C_NONE} cls_e;
  function automatic logic [1:0] grp(input logic [UREG_W-1:0] a);
    return SEL2_MASK[a] ? 2'b10 : SEL1_MASK[a] ? 2'b01 : SEL0_MASK[a] ? 2'b00 : 2'b11;
  endfunction
  function automatic logic [3:0] sel(input cls_e c, input logic [UREG_W-1:0] a);
    return c == C_IMM ? 4'b1110 : c == C_POP ? 4'b0101 : c == C_RD ? 4'b1100 :
           (c == C_WR || c == C_UR) ? {grp(a), 2'b01} : 4'b1111;
  endfunction
  logic              dm;
  cls_e              cls_in;
  logic [UREG_W-1:0] addr_in;
  logic [1:0]        drr_q, drr_d, di_q, di_d;
  logic              beat_q, beat_d, busy_q, busy_d;
  assign dm      = ps_dminst | ps_dmiaddinst;
  assign cls_in  = (ps_imminst | ps_dmimminst) ? C_IMM : ps_popstck ? C_POP :
                   (dm & !ps_dm_wrb) ? C_RD : ((dm & ps_dm_wrb) | ps_pshstck) ? C_WR :
                   ps_urgtrnsinst ? C_UR : C_NONE;
  assign addr_in = cls_in == C_UR ? ps_ureg2_add : ps_ureg1_add;
`ifdef PS_BC_LW_EN
  typedef enum logic {IDLE, BEAT1} st_e;
  st_e               st_q, st_d;
  cls_e              cls_q, cls_d;
  logic [UREG_W-2:0] addr_q, addr_d;
  logic              start;
  assign start = ps_lw & (cls_in == C_RD || cls_in == C_WR || cls_in == C_UR);
  always_comb begin
    st_d   = st_q;
    cls_d  = cls_q;
    addr_d = addr_q;
    {drr_d, di_d} = {drr_q, di_q};
    beat_d = beat_q;
    busy_d = busy_q;
    if (!ps_hold && st_q == BEAT1) begin
      {drr_d, di_d} = sel(cls_q, {addr_q, 1'b1});
      beat_d = 1'b1;
      busy_d = 1'b0;
      st_d   = IDLE;
    end else if (!ps_hold) begin
      {drr_d, di_d} = sel(cls_in, addr_in);
      beat_d = 1'b0;
      busy_d = start;
      st_d   = start ? BEAT1 : IDLE;
      cls_d  = cls_in;
      addr_d = addr_in[UREG_W-1:1];
    end
  end
  always_ff @(posedge clk_dcd or negedge ps_rst_n)
    if (!ps_rst_n) begin
      st_q   <= IDLE;
      cls_q  <= C_NONE;
      addr_q <= '0;
    end else begin
      st_q   <= st_d;
      cls_q  <= cls_d;
      addr_q <= addr_d;
    end
`else
  logic lw_unused;
  assign lw_unused = ps_lw;
  always_comb begin
    {drr_d, di_d} = ps_hold ? {drr_q, di_q} : sel(cls_in, addr_in);
    beat_d = 1'b0;
    busy_d = 1'b0;
  end
`endif
  always_ff @(posedge clk_dcd or negedge ps_rst_n)
    if (!ps_rst_n) begin
      drr_q  <= 2'b11;
      di_q   <= 2'b11;
      beat_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      drr_q  <= drr_d;
      di_q   <= di_d;
      beat_q <= beat_d;
      busy_q <= busy_d;
    end
  assign ps_bc_drr_slct = drr_q;
  assign ps_bc_di_slct  = di_q;
  assign ps_bc_beat     = beat_q;
  assign ps_bc_busy     = busy_q;
endmodule

// File: tb/tb_ps_bc_slct_seq.sv
// tb_ps_bc_slct_seq: scoreboard bench for ps_bc_slct_seq; expected {drr,di,beat,busy}
// words are queued by the stimulus and popped by a monitor one cycle later.
module tb_ps_bc_slct_seq;
  logic clk_dcd = 1'b0, ps_rst_n = 1'b0;
  logic ps_imminst, ps_dmimminst, ps_popstck, ps_pshstck, ps_dminst, ps_dmiaddinst;
  logic ps_urgtrnsinst, ps_dm_wrb, ps_lw, ps_hold;
  logic [3:0] ps_ureg1_add, ps_ureg2_add;
  logic [1:0] ps_bc_drr_slct, ps_bc_di_slct;
  logic ps_bc_beat, ps_bc_busy;
  int checks = 0, failures = 0;
  typedef struct {string n; logic [5:0] e;} exp_t;
  exp_t q[$];

  ps_bc_slct_seq dut (
    .clk_dcd(clk_dcd), .ps_rst_n(ps_rst_n),
    .ps_imminst(ps_imminst), .ps_dmimminst(ps_dmimminst), .ps_popstck(ps_popstck),
    .ps_pshstck(ps_pshstck), .ps_dminst(ps_dminst), .ps_dmiaddinst(ps_dmiaddinst),
    .ps_urgtrnsinst(ps_urgtrnsinst), .ps_dm_wrb(ps_dm_wrb), .ps_lw(ps_lw), .ps_hold(ps_hold),
    .ps_ureg1_add(ps_ureg1_add), .ps_ureg2_add(ps_ureg2_add),
    .ps_bc_drr_slct(ps_bc_drr_slct), .ps_bc_di_slct(ps_bc_di_slct),
    .ps_bc_beat(ps_bc_beat), .ps_bc_busy(ps_bc_busy)
  );

  always #5 clk_dcd = ~clk_dcd;

  task automatic chk(input string n, input logic [5:0] a, input logic [5:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", n, a, e);
    end
  endtask

  always @(posedge clk_dcd) begin
    #1;
    if (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      chk(x.n, {ps_bc_drr_slct, ps_bc_di_slct, ps_bc_beat, ps_bc_busy}, x.e);
    end
  end

  task automatic clr();
    {ps_imminst, ps_dmimminst, ps_popstck, ps_pshstck, ps_dminst, ps_dmiaddinst} = '0;
    {ps_urgtrnsinst, ps_dm_wrb, ps_lw, ps_hold} = '0;
    ps_ureg1_add = '0;
    ps_ureg2_add = '0;
  endtask

  task automatic cyc(input string n, input logic [5:0] e);
    q.push_back('{n, e});
    @(negedge clk_dcd);
    clr();
  endtask

  task automatic reset_mid(input string n);
    #2 ps_rst_n = 1'b0;
    #1 chk(n, {ps_bc_drr_slct, ps_bc_di_slct, ps_bc_beat, ps_bc_busy}, 6'b111100);
    @(negedge clk_dcd);
    ps_rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    @(negedge clk_dcd);
    chk("reset_init", {ps_bc_drr_slct, ps_bc_di_slct, ps_bc_beat, ps_bc_busy}, 6'b111100);
    ps_rst_n = 1'b1;
    ps_pshstck = 1; ps_ureg1_add = 4'h7; cyc("push_u7", 6'b010100);
    ps_pshstck = 1; ps_ureg1_add = 4'h0; cyc("push_u0", 6'b100100);
    ps_pshstck = 1; ps_ureg1_add = 4'h2; cyc("push_u2", 6'b000100);
    ps_pshstck = 1; ps_ureg1_add = 4'h5; cyc("push_u5", 6'b110100);
    ps_imminst = 1; ps_popstck = 1; cyc("prio_imm_pop", 6'b111000);
    ps_popstck = 1; ps_dminst = 1; cyc("prio_pop_dmrd", 6'b010100);
    ps_dminst = 1; cyc("dm_read", 6'b110000);
    ps_dminst = 1; ps_dm_wrb = 1; ps_ureg1_add = 4'h6; cyc("dm_write_u6", 6'b010100);
    ps_dmiaddinst = 1; ps_dm_wrb = 1; ps_ureg1_add = 4'h0; cyc("dmiadd_write_u0", 6'b100100);
    ps_urgtrnsinst = 1; ps_ureg2_add = 4'h1; ps_ureg1_add = 4'h7; cyc("urg_u1", 6'b000100);
    ps_dmimminst = 1; cyc("dmimm", 6'b111000);
    cyc("none", 6'b111100);
    ps_pshstck = 1; ps_ureg1_add = 4'h7; cyc("pre_hold", 6'b010100);
    ps_hold = 1; ps_imminst = 1; cyc("hold_a", 6'b010100);
    ps_hold = 1; ps_imminst = 1; cyc("hold_b", 6'b010100);
    ps_imminst = 1; cyc("hold_release", 6'b111000);
`ifdef PS_BC_LW_EN
    ps_urgtrnsinst = 1; ps_ureg2_add = 4'h6; ps_lw = 1; cyc("lw_urg_b0", 6'b010101);
    ps_imminst = 1; cyc("lw_urg_b1", 6'b010110);
    ps_pshstck = 1; ps_ureg1_add = 4'h0; ps_lw = 1; cyc("lw_push_b0", 6'b100101);
    ps_popstck = 1; cyc("lw_push_b1", 6'b000110);
    ps_dminst = 1; ps_lw = 1; cyc("lw_rd_b0", 6'b110001);
    cyc("lw_rd_b1", 6'b110010);
    ps_imminst = 1; ps_lw = 1; cyc("lw_ignored_imm", 6'b111000);
    cyc("lw_ignored_next", 6'b111100);
    ps_dminst = 1; ps_dm_wrb = 1; ps_ureg1_add = 4'h0; ps_lw = 1; cyc("lwh_b0", 6'b100101);
    for (int i = 0; i < 3; i++) begin
      ps_hold = 1; ps_imminst = 1; cyc("lwh_held", 6'b100101);
    end
    cyc("lwh_b1", 6'b000110);
    ps_urgtrnsinst = 1; ps_ureg2_add = 4'h0; ps_lw = 1; cyc("lwr_b0", 6'b100101);
    reset_mid("reset_mid_beat1");
    cyc("post_reset_idle", 6'b111100);
`else
    ps_dminst = 1; ps_lw = 1; cyc("nolw_rd", 6'b110000);
    cyc("nolw_next", 6'b111100);
    ps_pshstck = 1; ps_ureg1_add = 4'h0; cyc("pre_reset", 6'b100100);
    reset_mid("reset_mid");
    cyc("post_reset", 6'b111100);
`endif
    repeat (2) @(negedge clk_dcd);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps_bc_slct_seq.md
# ps_bc_slct_seq

Parametrised successor to the bus-connect select control in the program sequencer. Decodes instruction-class flags and universal-register addresses into registered DRR-mux and DI-mux selects for the bus-connect path. Adds three things to the base function: a parameter-driven register-group map, a pipeline hold, and a two-beat long-word sequencer. It sits between the instruction decoder and the bus-connect datapath, clocked on the decode clock.

## Interface
Parameters:
- UREG_W, 4: universal-register address width.
- SEL2_MASK, 16'h0001: one-hot set of ureg addresses selecting DRR source 2'b10. Width is 2**UREG_W.
- SEL1_MASK, 16'h00C0: addresses selecting DRR source 2'b01.
- SEL0_MASK, 16'h0006: addresses selecting DRR source 2'b00.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk_dcd, in, 1: decode clock. All state changes on its rising edge.
  - ps_rst_n, in, 1: asynchronous active-low reset.
- Instruction-class flags, each in, 1:
  - ps_imminst, ps_dmimminst: immediate class.
  - ps_popstck, ps_pshstck: stack pop and push.
  - ps_dminst, ps_dmiaddinst: DM access.
  - ps_urgtrnsinst: ureg transfer.
- ps_dm_wrb, in, 1: DM direction (1 = write).
- ps_lw, in, 1: long-word (two-beat) access.
- ps_hold, in, 1: pipeline freeze.
- ps_ureg1_add, in, UREG_W: source ureg for DM write and push.
- ps_ureg2_add, in, UREG_W: source ureg for ureg transfer.
- ps_bc_drr_slct, out, 2: registered DRR select.
- ps_bc_di_slct, out, 2: registered DI select.
- ps_bc_beat, out, 1: 0 = first beat, 1 = second beat.
- ps_bc_busy, out, 1: high while in BEAT1. The decoder must stall on it.

## Operation
- Group map map(a):
  - SEL2_MASK[a] → 2'b10.
  - else SEL1_MASK[a] → 2'b01.
  - else SEL0_MASK[a] → 2'b00.
  - else 2'b11.
  - Masks are checked in that order, so overlapping masks resolve by this priority.
- Class decode, strict priority (drr, di):
  1. imm | dmimm → (11, 10).
  2. pop → (01, 01).
  3. (dm | dmiadd) & !wrb → (11, 00).
  4. ((dm | dmiadd) & wrb) | push → (map(ureg1), 01).
  5. urgtrns → (map(ureg2), 01).
  6. none → (11, 11).
- FSM states:
  - IDLE: decode the inputs. Register the decoded selects with beat = 0.
    - Classes 3, 4 or 5 with ps_lw = 1 go to BEAT1. The class and address are latched.
    - ps_lw is ignored for classes 1, 2 and 6.
  - BEAT1: decode inputs are ignored. Re-evaluate the latched class with the address forced to {addr[UREG_W-1:1], 1'b1} (pair register). Register the result with beat = 1, then return to IDLE.
- ps_bc_busy = (state == BEAT1), registered.
- ps_hold = 1 freezes the state, the latch and all outputs. The FSM does not advance.

## Timing
- Reset values: ps_bc_drr_slct = 2'b11, ps_bc_di_slct = 2'b11, ps_bc_beat = 0, ps_bc_busy = 0, state IDLE.
- Latency: decode inputs sampled at edge N appear on the outputs after edge N. Both selects are aligned in the same cycle.
- Long-word sequence:
  - Edge N: beat 0 outputs; busy = 1.
  - Edge N+1: beat 1 outputs; busy = 0.
  - Inputs present during the BEAT1 cycle are dropped. The decoder must hold them, using busy.
- Hold during BEAT1: the second beat is delayed by one cycle per held cycle. busy stays 1.
- Reset asserted mid-BEAT1: the pending second beat is discarded, and all outputs return to their reset values asynchronously.
- Reset deassertion: the first decode takes effect at the first rising edge after ps_rst_n is released.

## Configuration
- PS_BC_LW_EN:
  - Defined: the two-beat long-word sequencer is present as described.
  - Undefined:
    - ps_lw is ignored.
    - The FSM and latch are removed.
    - ps_bc_beat and ps_bc_busy are tied to 0.
    - The block is a single registered decode stage with hold.

## Test plan
- Reset: drive ps_rst_n low mid-cycle → outputs become drr 11, di 11, beat 0, busy 0 immediately.
- Push with ureg1 = 4'h7 and default masks → next cycle drr 01, di 01. Repeat with ureg1 = 4'h0 → drr 10; with 4'h2 → drr 00; with 4'h5 → drr 11.
- Priority: imminst and popstck together → drr 11, di 10. popstck and dminst with wrb = 0 → drr 01, di 01.
- Long word (PS_BC_LW_EN defined): urgtrns with ureg2 = 4'h6 and ps_lw = 1.
  - Cycle 1: drr 01, di 01, beat 0, busy 1.
  - Cycle 2: address 4'h7, drr 01, beat 1, busy 0.
  - An imminst presented in cycle 1 is ignored.
- Hold: assert ps_hold for 3 cycles in BEAT1 → outputs and busy are frozen; the beat-1 result appears on the edge after hold drops.
- Build without PS_BC_LW_EN, DM read with ps_lw = 1 → a single cycle of drr 11, di 00; beat and busy stay 0.
